axis_row_assembler: RTL and testbench



---
 rtl/axis_row_assembler_if.sv | 28 ++
 rtl/axis_row_assembler.sv | 148 ++++++++++++++
 tb/tb_axis_row_assembler.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_row_assembler_if.sv
// Stream bundle for axis_row_assembler: narrow pixel input (S_AXIS_*) and wide
// row-group output (M_AXIS_*). The slave modport is the assembler's view.
interface axis_row_assembler_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int CONV_UNITS   = 8,
  parameter int KERNEL_H_MAX = 5
);
  localparam int VEC_LEN = CONV_UNITS + KERNEL_H_MAX - 1;

  logic [DATA_WIDTH-1:0] S_AXIS_tdata;
  logic                  S_AXIS_tvalid;
  logic                  S_AXIS_tready;
  logic                  S_AXIS_tlast;
  logic [DATA_WIDTH-1:0] M_AXIS_tdata [VEC_LEN];
  logic                  M_AXIS_tvalid;
  logic                  M_AXIS_tready;
  logic                  M_AXIS_tlast;

  modport slave (
    input  S_AXIS_tdata, S_AXIS_tvalid, S_AXIS_tlast, M_AXIS_tready,
    output S_AXIS_tready, M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tlast
  );

  modport master (
    output S_AXIS_tdata, S_AXIS_tvalid, S_AXIS_tlast, M_AXIS_tready,
    input  S_AXIS_tready, M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tlast
  );
endinterface

// File: rtl/axis_row_assembler.sv
// Packs CONV_UNITS+kernel_h_1 consecutive pixels into one wide beat for the shift buffer.
// Optional macro AXIS_ROW_ASSEMBLER_TLAST_CHECK_EN adds the sticky tlast_err output.
module axis_row_assembler #(
  parameter int DATA_WIDTH         = 16,
  parameter int CONV_UNITS         = 8,
  parameter int KERNEL_H_MAX       = 5,
  parameter int CIN_COUNTER_WIDTH  = 5,
  parameter int COLS_COUNTER_WIDTH = 10
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              start,
  output logic                              done,
  input  logic [$clog2(KERNEL_H_MAX+1)-1:0] kernel_h_1_in,
  input  logic [COLS_COUNTER_WIDTH-1:0]     cols_1,
  input  logic [CIN_COUNTER_WIDTH-1:0]      cin_1,
`ifdef AXIS_ROW_ASSEMBLER_TLAST_CHECK_EN
  output logic                              tlast_err,
`endif
  axis_row_assembler_if.slave               axis
);
  localparam int VEC_LEN = CONV_UNITS + KERNEL_H_MAX - 1;
  localparam int KHW     = $clog2(KERNEL_H_MAX + 1);
  localparam int WCW     = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                        state;
  logic [KHW-1:0]                kh_1;
  logic [COLS_COUNTER_WIDTH-1:0] cols_1_q, col_cnt;
  logic [CIN_COUNTER_WIDTH-1:0]  cin_1_q, cin_cnt;
  logic [WCW-1:0]                word_cnt, r_last;

  logic [DATA_WIDTH-1:0] fill_p0 [VEC_LEN];
  logic                  vld_p0, last_p0;
  logic [DATA_WIDTH-1:0] out_p1 [VEC_LEN];
  logic                  vld_p1, last_p1;

  logic accept, xfer, word_last, group_last, frame_last;

  assign r_last     = WCW'(CONV_UNITS - 1) + WCW'(kh_1);
  // The fill register counts as free in the very cycle it hands off, so input never bubbles.
  assign xfer       = vld_p0 && (!vld_p1 || axis.M_AXIS_tready);
  assign axis.S_AXIS_tready = (state == RUN) && (!vld_p0 || xfer);
  assign accept     = axis.S_AXIS_tvalid && axis.S_AXIS_tready;
  assign word_last  = (word_cnt == r_last);
  assign group_last = (cin_cnt == cin_1_q) && (col_cnt == cols_1_q);
  assign frame_last = word_last && group_last;

  assign axis.M_AXIS_tdata  = out_p1;
  assign axis.M_AXIS_tvalid = vld_p1;
  assign axis.M_AXIS_tlast  = last_p1;

  always_ff @(posedge aclk) begin
    done <= 1'b0;
    if (areset) begin
      state    <= IDLE;
      kh_1     <= '0;
      cols_1_q <= '0;
      cin_1_q  <= '0;
      word_cnt <= '0;
      cin_cnt  <= '0;
      col_cnt  <= '0;
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
`ifdef AXIS_ROW_ASSEMBLER_TLAST_CHECK_EN
      tlast_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          kh_1     <= kernel_h_1_in;
          cols_1_q <= cols_1;
          cin_1_q  <= cin_1;
          word_cnt <= '0;
          cin_cnt  <= '0;
          col_cnt  <= '0;
`ifdef AXIS_ROW_ASSEMBLER_TLAST_CHECK_EN
          tlast_err <= 1'b0;
`endif
          state    <= RUN;
        end
        RUN:   if (accept && frame_last) state <= DRAIN;
        DRAIN: if (vld_p1 && axis.M_AXIS_tready && last_p1) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        if (word_last) begin
          word_cnt <= '0;
          if (cin_cnt == cin_1_q) begin
            cin_cnt <= '0;
            col_cnt <= group_last ? '0 : col_cnt + 1'b1;
          end else begin
            cin_cnt <= cin_cnt + 1'b1;
          end
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end

      // Stage p0 -> p1: fill register full flag and its end-of-frame marker.
      if (accept && word_last) begin
        vld_p0  <= 1'b1;
        last_p0 <= group_last;
      end else if (xfer) begin
        vld_p0  <= 1'b0;
      end

      if (xfer) begin
        vld_p1  <= 1'b1;
        last_p1 <= last_p0;
      end else if (axis.M_AXIS_tready) begin
        vld_p1  <= 1'b0;
      end

`ifdef AXIS_ROW_ASSEMBLER_TLAST_CHECK_EN
      if (accept && (axis.S_AXIS_tlast != frame_last)) tlast_err <= 1'b1;
`endif
    end
  end

  // Stage p0: slot k of the current group; unused upper slots zeroed on the first word.
  always_ff @(posedge aclk) begin
    if (accept) begin
      fill_p0[word_cnt] <= axis.S_AXIS_tdata;
      if (word_cnt == '0) begin
        for (int i = 0; i < VEC_LEN; i++) begin
          if (WCW'(i) > r_last) fill_p0[i] <= '0;
        end
      end
    end
  end

  // Stage p1: output beat, held while the consumer stalls.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < VEC_LEN; i++) out_p1[i] <= '0;
    end else if (xfer) begin
      out_p1 <= fill_p0;
    end
  end
endmodule

// File: tb/tb_axis_row_assembler.sv
// Randomized self-checking bench for axis_row_assembler against a slot-index reference model.
module tb_axis_row_assembler;
  localparam int DW = 16, CU = 8, KHM = 5, CINW = 5, COLW = 10;
  localparam int VL = CU + KHM - 1;

  logic            aclk = 1'b0;
  logic            areset, start, done;
  logic [2:0]      kernel_h_1_in;
  logic [COLW-1:0] cols_1;
  logic [CINW-1:0] cin_1;
`ifdef AXIS_ROW_ASSEMBLER_TLAST_CHECK_EN
  logic            tlast_err;
`endif

  axis_row_assembler_if #(.DATA_WIDTH(DW), .CONV_UNITS(CU), .KERNEL_H_MAX(KHM)) axis ();

  axis_row_assembler #(
    .DATA_WIDTH(DW), .CONV_UNITS(CU), .KERNEL_H_MAX(KHM),
    .CIN_COUNTER_WIDTH(CINW), .COLS_COUNTER_WIDTH(COLW)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start), .done(done),
    .kernel_h_1_in(kernel_h_1_in), .cols_1(cols_1), .cin_1(cin_1),
`ifdef AXIS_ROW_ASSEMBLER_TLAST_CHECK_EN
    .tlast_err(tlast_err),
`endif
    .axis(axis)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  logic [DW-1:0] words[$];
  logic [DW-1:0] cap_words[$];
  bit            cap_last[$];
  int            acc_cyc[$];
  int  done_cnt = 0, done_cyc = -1, hs_cyc = -1, first_vld_cyc = -1, err_cyc = -1;
  bit  saw_bp = 0, stall_armed = 0, prev_last;
  logic [DW-1:0] prev_data [VL];

  // Monitor: samples on the falling edge, between driver updates and the active edge.
  initial begin
    forever begin
      @(negedge aclk);
      cyc++;
      if (axis.S_AXIS_tvalid && axis.S_AXIS_tready) acc_cyc.push_back(cyc);
      if (axis.M_AXIS_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (axis.S_AXIS_tvalid && !axis.S_AXIS_tready && axis.M_AXIS_tvalid && !axis.M_AXIS_tready)
        saw_bp = 1;
      if (stall_armed) begin
        bit bad;
        bad = (axis.M_AXIS_tlast !== prev_last) || !axis.M_AXIS_tvalid;
        for (int s = 0; s < VL; s++) if (axis.M_AXIS_tdata[s] !== prev_data[s]) bad = 1;
        n_checks++;
        if (bad) begin
          n_fail++;
          $display("FAIL hold_stable cyc=%0d: output beat changed while stalled (slot0 got %h, required %h)",
                   cyc, axis.M_AXIS_tdata[0], prev_data[0]);
        end
      end
      if (axis.M_AXIS_tvalid && axis.M_AXIS_tready) begin
        for (int s = 0; s < VL; s++) cap_words.push_back(axis.M_AXIS_tdata[s]);
        cap_last.push_back(axis.M_AXIS_tlast);
        hs_cyc = cyc;
      end
      stall_armed = axis.M_AXIS_tvalid && !axis.M_AXIS_tready;
      prev_last   = axis.M_AXIS_tlast;
      for (int s = 0; s < VL; s++) prev_data[s] = axis.M_AXIS_tdata[s];
      if (done) begin done_cnt++; done_cyc = cyc; end
`ifdef AXIS_ROW_ASSEMBLER_TLAST_CHECK_EN
      if (tlast_err && err_cyc < 0) err_cyc = cyc;
`endif
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic clear_capture();
    cap_words.delete(); cap_last.delete(); acc_cyc.delete();
    done_cnt = 0; done_cyc = -1; hs_cyc = -1; first_vld_cyc = -1; err_cyc = -1; saw_bp = 0;
  endtask

  // Drives one frame; returns timed_out if input or done did not complete in budget.
  task automatic run_frame(input int kh, input int cols, input int cin, input int gap_at,
                           input int gap_len, input int stall_at, input int stall_len,
                           input bit seq, input int tlast_at, output bit timed_out);
    int n, k, guard;
    n = (CU + kh) * (cols + 1) * (cin + 1);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(seq ? DW'(i) : DW'($urandom_range(0, 65535)));
    clear_capture();
    @(posedge aclk); #1;
    kernel_h_1_in = 3'(kh); cols_1 = COLW'(cols); cin_1 = CINW'(cin); start = 1;
    @(posedge aclk); #1;
    start = 0;
    k = 0;
    fork
      begin
        int g = 0;
        while (k < n && g < 20000) begin
          if (k == gap_at && gap_len > 0) begin
            axis.S_AXIS_tvalid = 0;
            repeat (gap_len) @(posedge aclk);
            #1;
            gap_at = -1;
          end
          axis.S_AXIS_tvalid = 1;
          axis.S_AXIS_tdata  = words[k];
          axis.S_AXIS_tlast  = (k == tlast_at);
          @(negedge aclk);
          if (axis.S_AXIS_tready) k++;
          @(posedge aclk); #1;
          g++;
        end
        axis.S_AXIS_tvalid = 0;
        axis.S_AXIS_tlast  = 0;
      end
      begin
        axis.M_AXIS_tready = 1;
        if (stall_len > 0) begin
          repeat (stall_at) @(posedge aclk);
          #1 axis.M_AXIS_tready = 0;
          repeat (stall_len) @(posedge aclk);
          #1 axis.M_AXIS_tready = 1;
        end
      end
    join
    guard = 0;
    while (done_cnt == 0 && guard < 2000) begin @(posedge aclk); guard++; end
    repeat (3) @(posedge aclk);
    #1;
    timed_out = (k < n) || (done_cnt == 0);
  endtask

  task automatic test_reset();
    bit bad;
    areset = 1; start = 0; kernel_h_1_in = 0; cols_1 = 0; cin_1 = 0;
    axis.S_AXIS_tvalid = 0; axis.S_AXIS_tdata = 0; axis.S_AXIS_tlast = 0; axis.M_AXIS_tready = 1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b required 0", done); end
    n_checks++; if (axis.S_AXIS_tready !== 1'b0) begin n_fail++; $display("FAIL reset_s_tready got %b required 0", axis.S_AXIS_tready); end
    n_checks++; if (axis.M_AXIS_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid got %b required 0", axis.M_AXIS_tvalid); end
    n_checks++; if (axis.M_AXIS_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_m_tlast got %b required 0", axis.M_AXIS_tlast); end
    bad = 0;
    for (int s = 0; s < VL; s++) if (axis.M_AXIS_tdata[s] !== '0) bad = 1;
    n_checks++; if (bad) begin n_fail++; $display("FAIL reset_tdata got slot0=%h required all zero", axis.M_AXIS_tdata[0]); end
    @(posedge aclk); #1 areset = 0;
    @(negedge aclk);
    n_checks++; if (axis.S_AXIS_tready !== 1'b0) begin n_fail++; $display("FAIL idle_s_tready got %b required 0", axis.S_AXIS_tready); end
  endtask

  task automatic test_basic();
    bit to; int bad;
    run_frame(0, 3, 4, -1, 0, 0, 0, 1, 159, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout got timeout required completion"); end
    n_checks++; if (cap_last.size() != 20) begin n_fail++; $display("FAIL basic_beats got %0d required 20", cap_last.size()); end
    bad = 0;
    for (int b = 0; b < cap_last.size() && b < 20; b++) begin
      for (int s = 0; s < VL; s++) if (cap_words[b*VL+s] !== ((s < 8) ? DW'(8*b+s) : DW'(0))) bad++;
      if (cap_last[b] !== (b == 19)) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL basic_data got %0d wrong fields required 0", bad); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count got %0d required 1", done_cnt); end
    n_checks++; if (done_cyc != hs_cyc + 1) begin n_fail++; $display("FAIL basic_done_timing got %0d required %0d", done_cyc, hs_cyc + 1); end
    if (acc_cyc.size() == 160) begin
      n_checks++; if (first_vld_cyc - acc_cyc[7] != 2) begin n_fail++; $display("FAIL basic_latency got %0d required 2", first_vld_cyc - acc_cyc[7]); end
      n_checks++; if (acc_cyc[159] - acc_cyc[0] != 159) begin n_fail++; $display("FAIL basic_throughput got %0d required 159", acc_cyc[159] - acc_cyc[0]); end
    end else begin
      n_checks++; n_fail++; $display("FAIL basic_accepts got %0d required 160", acc_cyc.size());
    end
`ifdef AXIS_ROW_ASSEMBLER_TLAST_CHECK_EN
    n_checks++; if (tlast_err !== 1'b0) begin n_fail++; $display("FAIL basic_tlast_err got %b required 0", tlast_err); end
`endif
  endtask

  task automatic test_kh4();
    bit to; int bad;
    run_frame(4, 0, 1, -1, 0, 0, 0, 0, 23, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL kh4_timeout got timeout required completion"); end
    n_checks++; if (cap_last.size() != 2) begin n_fail++; $display("FAIL kh4_beats got %0d required 2", cap_last.size()); end
    bad = 0;
    for (int b = 0; b < cap_last.size() && b < 2; b++) begin
      for (int s = 0; s < VL; s++) if (cap_words[b*VL+s] !== words[12*b+s]) bad++;
      if (cap_last[b] !== (b == 1)) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL kh4_data got %0d wrong fields required 0", bad); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL kh4_done got %0d required 1", done_cnt); end
  endtask

  task automatic test_out_stall();
    bit to; int bad;
    run_frame(0, 3, 4, -1, 0, 10, 30, 0, 159, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL stall_timeout got timeout required completion"); end
    n_checks++; if (saw_bp !== 1'b1) begin n_fail++; $display("FAIL stall_backpressure got %b required 1", saw_bp); end
    n_checks++; if (cap_last.size() != 20) begin n_fail++; $display("FAIL stall_beats got %0d required 20", cap_last.size()); end
    bad = 0;
    for (int b = 0; b < cap_last.size() && b < 20; b++) begin
      for (int s = 0; s < VL; s++) if (cap_words[b*VL+s] !== ((s < 8) ? words[8*b+s] : DW'(0))) bad++;
      if (cap_last[b] !== (b == 19)) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_data got %0d wrong fields required 0", bad); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done got %0d required 1", done_cnt); end
  endtask

  task automatic test_in_gap();
    bit to; int bad;
    run_frame(0, 3, 4, 29, 9, 0, 0, 1, 159, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL gap_timeout got timeout required completion"); end
    n_checks++; if (cap_last.size() != 20) begin n_fail++; $display("FAIL gap_beats got %0d required 20", cap_last.size()); end
    bad = 0;
    for (int b = 0; b < cap_last.size() && b < 20; b++) begin
      for (int s = 0; s < VL; s++) if (cap_words[b*VL+s] !== ((s < 8) ? DW'(8*b+s) : DW'(0))) bad++;
      if (cap_last[b] !== (b == 19)) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL gap_data got %0d wrong fields required 0", bad); end
  endtask

  task automatic test_abort();
    bit to, bad;
    int nbad;
    clear_capture();
    @(posedge aclk); #1;
    kernel_h_1_in = 0; cols_1 = 3; cin_1 = 4; start = 1; axis.M_AXIS_tready = 1;
    @(posedge aclk); #1 start = 0;
    for (int i = 0; i < 13; i++) begin
      axis.S_AXIS_tvalid = 1; axis.S_AXIS_tdata = DW'($urandom_range(0, 65535));
      @(posedge aclk); #1;
    end
    axis.S_AXIS_tvalid = 0; areset = 1;
    @(posedge aclk);
    @(negedge aclk);
    n_checks++; if (axis.M_AXIS_tvalid !== 1'b0) begin n_fail++; $display("FAIL abort_m_tvalid got %b required 0", axis.M_AXIS_tvalid); end
    n_checks++; if (axis.S_AXIS_tready !== 1'b0) begin n_fail++; $display("FAIL abort_s_tready got %b required 0", axis.S_AXIS_tready); end
    bad = 0;
    for (int s = 0; s < VL; s++) if (axis.M_AXIS_tdata[s] !== '0) bad = 1;
    n_checks++; if (bad) begin n_fail++; $display("FAIL abort_tdata got slot0=%h required all zero", axis.M_AXIS_tdata[0]); end
    @(posedge aclk); #1 areset = 0;
    repeat (20) @(posedge aclk);
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done got %0d required 0", done_cnt); end
    run_frame(0, 3, 4, -1, 0, 0, 0, 0, 159, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL abort_restart_timeout got timeout required completion"); end
    nbad = 0;
    if (cap_last.size() != 20) nbad++;
    for (int b = 0; b < cap_last.size() && b < 20; b++)
      for (int s = 0; s < VL; s++) if (cap_words[b*VL+s] !== ((s < 8) ? words[8*b+s] : DW'(0))) nbad++;
    n_checks++; if (nbad != 0) begin n_fail++; $display("FAIL abort_restart_data got %0d wrong fields required 0", nbad); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL abort_restart_done got %0d required 1", done_cnt); end
  endtask

`ifdef AXIS_ROW_ASSEMBLER_TLAST_CHECK_EN
  task automatic test_tlast_err();
    bit to;
    run_frame(0, 3, 4, -1, 0, 0, 0, 0, 10, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL tlerr_timeout got timeout required completion"); end
    n_checks++; if (tlast_err !== 1'b1) begin n_fail++; $display("FAIL tlerr_sticky got %b required 1", tlast_err); end
    if (acc_cyc.size() > 10) begin
      n_checks++; if (err_cyc != acc_cyc[10] + 1) begin n_fail++; $display("FAIL tlerr_timing got %0d required %0d", err_cyc, acc_cyc[10] + 1); end
    end
    @(posedge aclk); #1 start = 1;
    @(posedge aclk); #1 start = 0;
    @(negedge aclk);
    n_checks++; if (tlast_err !== 1'b0) begin n_fail++; $display("FAIL tlerr_clear got %b required 0", tlast_err); end
    @(posedge aclk); #1 areset = 1;
    @(posedge aclk); #1 areset = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_kh4();
    test_out_stall();
    test_in_gap();
    test_abort();
`ifdef AXIS_ROW_ASSEMBLER_TLAST_CHECK_EN
    test_tlast_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
